clk_div_multi: RTL and testbench



---
 rtl/clk_div_multi_pkg.sv | 13 +
 rtl/clk_div_multi_chan.sv | 75 +++++++
 rtl/clk_div_multi.sv | 43 ++++
 tb/tb_clk_div_multi.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_multi_pkg.sv
// rtl/clk_div_multi_pkg.sv - shared constants and helpers for the clock divider
package clk_div_multi_pkg;

  localparam int DIV_MIN        = 2;
  localparam int DEFAULT_DIV_1K = 100000;
  localparam int SEL_W          = 4;

  // Divisors below DIV_MIN cannot form a high and a low phase, so they are raised.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// rtl/clk_div_multi_chan.sv - one divider channel: shadow/active divisor, counter, outputs
module clk_div_multi_chan
  import clk_div_multi_pkg::*;
#(
  parameter int DIV_W       = 17,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1K
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] s;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d_nxt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] wr_div;
  logic             wrap;
  logic             restart;

  assign wr_div = DIV_W'(clamp_div(32'(wr_data)));

  // Next active divisor and count; a period restart (wrap or sync) picks up the shadow divisor.
  always_comb begin
    wrap    = (cnt == d - 1'b1);
    restart = sync || wrap;
    d_nxt   = d;
    cnt_nxt = cnt + 1'b1;
    if (restart) begin
      d_nxt   = s;
      cnt_nxt = '0;
    end
  end

  // Channel state; a disabled channel parks at the end of a period so re-enable starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s       <= DIV_W'(DEFAULT_DIV);
      d       <= DIV_W'(DEFAULT_DIV);
      cnt     <= DIV_W'(DEFAULT_DIV - 1);
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (!en) begin
        d       <= s;
        cnt     <= s - 1'b1;
        clk_out <= 1'b0;
        tick    <= 1'b0;
        pending <= 1'b0;
      end else begin
        d       <= d_nxt;
        cnt     <= cnt_nxt;
        clk_out <= (cnt_nxt < (d_nxt >> 1));
        tick    <= (cnt_nxt == '0);
        if (restart) begin
          pending <= 1'b0;
        end
      end
      // A write on a restart edge lands after the old shadow was transferred, so it stays pending.
      if (wr) begin
        s       <= wr_div;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable divided-clock and tick generator
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 17,
  parameter int DEFAULT_DIV = DEFAULT_DIV_1K
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [DIV_W-1:0] wr_data,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  logic [N_CH-1:0] wr_hit;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    // Out-of-range wr_sel matches no channel, so such writes are dropped.
    assign wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));

    clk_div_multi_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .sync    (sync),
      .wr      (wr_hit[i]),
      .wr_data (wr_data),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
module tb_clk_div_multi;

  localparam int N_CH  = 4;
  localparam int DIV_W = 17;
  localparam int DEF   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             wr_en;
  logic [3:0]       wr_sel;
  logic [DIV_W-1:0] wr_data;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  clk_div_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] co;
    logic [N_CH-1:0] tk;
    logic [N_CH-1:0] pd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: position within the current period, restarted when not yet running.
  int              m_s[N_CH];
  int              m_p[N_CH];
  int              m_pos[N_CH];
  bit              m_run[N_CH];
  logic [N_CH-1:0] m_co;
  logic [N_CH-1:0] m_tk;
  logic [N_CH-1:0] m_pd;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_s[i] = DEF; m_p[i] = DEF; m_pos[i] = 0; m_run[i] = 0;
    end
    m_co = '0; m_tk = '0; m_pd = '0;
    sb.delete();
  endtask

  task automatic cycle();
    for (int i = 0; i < N_CH; i++) begin
      if (!en[i]) begin
        m_run[i] = 0; m_p[i] = m_s[i]; m_pd[i] = 0; m_co[i] = 0; m_tk[i] = 0;
      end else begin
        if (sync || !m_run[i] || m_pos[i] == m_p[i] - 1) begin
          m_p[i] = m_s[i]; m_pd[i] = 0; m_pos[i] = 0; m_run[i] = 1;
        end else begin
          m_pos[i]++;
        end
        m_co[i] = (m_pos[i] < m_p[i] / 2);
        m_tk[i] = (m_pos[i] == 0);
      end
      if (wr_en && wr_sel == i) begin
        m_s[i]  = (wr_data < 2) ? 2 : int'(wr_data);
        m_pd[i] = 1;
      end
    end
    sb.push_back(exp_t'{m_co, m_tk, m_pd});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = '0; sync = 0; wr_en = 0; wr_sel = 0; wr_data = '0;
    model_reset();
    #1;
    checks++;
    if ({clk_out, tick, pending} !== '0) begin
      errors++;
      $display("FAIL reset_state: clk_out=%b tick=%b pending=%b required all 0", clk_out, tick, pending);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_default();
    en = '1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      e = sb.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL default_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
      checks++;
      if (clk_out[0] !== ((k % 4) < 2) || tick[0] !== (k % 4 == 0) || pending !== '0) begin
        errors++;
        $display("FAIL default_pattern cyc%0d: clk_out0=%b tick0=%b pending=%b required %b %b 0000", k, clk_out[0], tick[0], pending, (k % 4) < 2, k % 4 == 0);
      end
    end
  endtask

  task automatic test_write5();
    wr_en = 1; wr_sel = 0; wr_data = 5;
    cycle();
    wr_en = 0;
    e = sb.pop_front();
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL write5_pending: pending0=%b required 1", pending[0]);
    end
    for (int k = 0; k < 14; k++) begin
      cycle();
      e = sb.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL write5_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
      if (k == 3) begin
        checks++;
        if (pending[0] !== 1'b0 || tick[0] !== 1'b1) begin
          errors++;
          $display("FAIL write5_apply: pending0=%b tick0=%b required 0 1", pending[0], tick[0]);
        end
      end
    end
  endtask

  task automatic test_write6();
    // Bring ch1 to count 1 of its 4-cycle period (a tick edge is count 0).
    for (int k = 0; k < 8 && !tick[1]; k++) begin
      cycle();
      void'(sb.pop_front());
    end
    cycle();
    void'(sb.pop_front());
    wr_en = 1; wr_sel = 1; wr_data = 6;
    cycle();
    wr_en = 0;
    e = sb.pop_front();
    checks++;
    if (pending[1] !== 1'b1 || {clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
      errors++;
      $display("FAIL write6_pending: %b %b %b required pending1=1 and %b %b %b", clk_out, tick, pending, e.co, e.tk, e.pd);
    end
    for (int k = 0; k < 14; k++) begin
      cycle();
      e = sb.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL write6_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
      if (k == 1 || k == 7) begin
        checks++;
        if (pending[1] !== 1'b0 || tick[1] !== 1'b1 || clk_out[1] !== 1'b1) begin
          errors++;
          $display("FAIL write6_wrap cyc%0d: pending1=%b tick1=%b clk_out1=%b required 0 1 1", k, pending[1], tick[1], clk_out[1]);
        end
      end
    end
  endtask

  task automatic test_write0();
    int ticks;
    bit cleared;
    wr_en = 1; wr_sel = 2; wr_data = 0;
    cycle();
    wr_sel = 4'd4; wr_data = 9;
    cycle();
    wr_en = 0;
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (pending !== e.pd || pending[3] !== 1'b0) begin
      errors++;
      $display("FAIL bad_sel_write: pending=%b required %b", pending, e.pd);
    end
    cleared = 0;
    for (int k = 0; k < 8 && !cleared; k++) begin
      cycle();
      void'(sb.pop_front());
      cleared = (pending[2] == 1'b0);
    end
    checks++;
    if (!cleared) begin
      errors++;
      $display("FAIL write0_timeout: pending2 still %b after 8 cycles, required 0", pending[2]);
    end
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      e = sb.pop_front();
      ticks += tick[2];
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL write0_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
    end
    checks++;
    if (ticks != 4) begin
      errors++;
      $display("FAIL write0_rate: ch2 ticks in 8 cycles=%0d required 4", ticks);
    end
  endtask

  task automatic test_sync();
    wr_en = 1; wr_sel = 0; wr_data = 4;
    cycle();
    wr_en = 0;
    void'(sb.pop_front());
    cycle();
    void'(sb.pop_front());
    sync = 1;
    cycle();
    sync = 0;
    e = sb.pop_front();
    checks++;
    if (tick[1:0] !== 2'b11 || clk_out[1:0] !== 2'b11 || pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL sync_align: tick=%b clk_out=%b pending=%b required tick/clk_out[1:0]=11 pending0=0", tick, clk_out, pending);
    end
    for (int k = 1; k <= 24; k++) begin
      cycle();
      e = sb.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL sync_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
      if (k == 12 || k == 24) begin
        checks++;
        if (tick[1:0] !== 2'b11) begin
          errors++;
          $display("FAIL sync_period cyc%0d: tick=%b required [1:0]=11", k, tick);
        end
      end
    end
  endtask

  task automatic test_enable();
    cycle();
    void'(sb.pop_front());
    en[0] = 0;
    cycle();
    e = sb.pop_front();
    checks++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || {clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
      errors++;
      $display("FAIL disable: clk_out=%b tick=%b required ch0 0 0 (model %b %b)", clk_out, tick, e.co, e.tk);
    end
    en[0] = 1;
    cycle();
    e = sb.pop_front();
    checks++;
    if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL reenable: tick0=%b clk_out0=%b required 1 1", tick[0], clk_out[0]);
    end
  endtask

  task automatic test_back_to_back();
    wr_en = 1; wr_sel = 3; wr_data = 7; sync = 1;
    cycle();
    sync = 0;
    e = sb.pop_front();
    checks++;
    if (pending[3] !== 1'b1 || tick[3] !== 1'b1) begin
      errors++;
      $display("FAIL sync_write: pending3=%b tick3=%b required 1 1", pending[3], tick[3]);
    end
    wr_data = 3;
    cycle();
    wr_en = 0;
    void'(sb.pop_front());
    for (int k = 0; k < 16; k++) begin
      cycle();
      e = sb.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL b2b_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
    end
  endtask

  task automatic test_reset_mid();
    wr_en = 1; wr_sel = 1; wr_data = 9;
    cycle();
    wr_en = 0;
    void'(sb.pop_front());
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({clk_out, tick, pending} !== '0) begin
      errors++;
      $display("FAIL reset_mid: clk_out=%b tick=%b pending=%b required all 0", clk_out, tick, pending);
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      e = sb.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== {e.co, e.tk, e.pd}) begin
        errors++;
        $display("FAIL post_reset_model cyc%0d: %b %b %b required %b %b %b", k, clk_out, tick, pending, e.co, e.tk, e.pd);
      end
      checks++;
      if (clk_out !== {N_CH{(k % 4) < 2}} || tick !== {N_CH{k % 4 == 0}}) begin
        errors++;
        $display("FAIL post_reset_div cyc%0d: clk_out=%b tick=%b required default period 4", k, clk_out, tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_write5();
    test_write6();
    test_write0();
    test_sync();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
